// File: rtl/rs_encoder_pkg.sv
// Shared Reed-Solomon encoder constants and types, plus helpers for the
// multi-source block arbiter that feeds a single encoder.
package rs_encoder_pkg;

    localparam int unsigned RS_K            = 223;
    localparam int unsigned RS_PARITY_BYTES = 32;
    localparam int unsigned RS_N            = RS_K + RS_PARITY_BYTES;

    typedef logic [7:0] rs_byte_t;

    typedef enum logic {
        ArbIdle,
        ArbBusy
    } arb_state_e;

    // Source id width: max(1, $clog2(n)).
    function automatic int unsigned rs_src_id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rs_tag_fifo.sv
// Small show-ahead synchronous FIFO holding the source id of each granted
// block until its codeword leaves the encoder.
module rs_tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointer MSB acts as a lap bit so full and empty are distinguishable.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rs_block_arbiter.sv
// Round-robin arbiter granting the shared RS encoder input to one source per
// RS_K-byte block, with a tag FIFO tracking which source owns each codeword.
module rs_block_arbiter
    import rs_encoder_pkg::*;
#(
    parameter int unsigned N_SRC     = 2,
    parameter int unsigned TAG_DEPTH = 4,
    localparam int unsigned SRC_ID_W = rs_src_id_w(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    output logic [N_SRC-1:0]     src_ready,
    input  logic [N_SRC*8-1:0]   src_data,
    output logic                 enc_valid,
    input  logic                 enc_ready,
    output rs_byte_t             enc_data,
    output logic                 enc_last,
    input  logic                 cw_valid,
    input  logic                 cw_ready,
    input  logic                 cw_last,
    output logic [SRC_ID_W-1:0]  cw_src_id,
    output logic                 cw_tag_valid,
    output logic                 tag_underflow
);

    localparam int unsigned          CNT_W    = $clog2(RS_K);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(RS_K - 1);
    localparam logic [SRC_ID_W-1:0] LAST_ID  = SRC_ID_W'(N_SRC - 1);

    arb_state_e          state;
    logic [CNT_W-1:0]    byte_cnt;
    logic [SRC_ID_W-1:0] gnt;
    logic [SRC_ID_W-1:0] last_gnt;
    logic [SRC_ID_W-1:0] winner;
    logic [SRC_ID_W-1:0] head;
    logic                any_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic                tag_push;
    logic                tag_pop;
    logic                underflow_q;
    logic                busy;
    logic                gnt_valid;
    logic                hs;
    rs_byte_t            gnt_data;
    int                  cand;

    // Scan from farthest to nearest so the nearest requester after last_gnt wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = int'(N_SRC); i >= 1; i--) begin
            cand = int'(last_gnt) + i;
            if (cand >= int'(N_SRC)) cand = cand - int'(N_SRC);
            if (src_valid[SRC_ID_W'(cand)]) begin
                winner  = SRC_ID_W'(cand);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (gnt == SRC_ID_W'(i)) begin
                gnt_valid = src_valid[i];
                gnt_data  = src_data[8*i +: 8];
            end
        end
    end

    // Everything is forced low while rst is held, independent of register state.
    always_comb begin
        busy      = (state == ArbBusy) && !rst;
        enc_valid = busy && gnt_valid;
        enc_data  = busy ? gnt_data : '0;
        enc_last  = busy && (byte_cnt == LAST_CNT);
        hs        = enc_valid && enc_ready;
        for (int i = 0; i < int'(N_SRC); i++) begin
            src_ready[i] = busy && (gnt == SRC_ID_W'(i)) && enc_ready;
        end
        tag_push      = (state == ArbIdle) && any_req && !fifo_full && !rst;
        tag_pop       = cw_valid && cw_ready && cw_last && !rst;
        cw_src_id     = rst ? '0 : head;
        cw_tag_valid  = !rst && !fifo_empty;
        tag_underflow = !rst && underflow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ArbIdle;
            byte_cnt    <= '0;
            gnt         <= '0;
            last_gnt    <= LAST_ID;
            underflow_q <= 1'b0;
        end else begin
            if (tag_pop && fifo_empty) underflow_q <= 1'b1;
            unique case (state)
                ArbIdle: begin
                    if (tag_push) begin
                        gnt   <= winner;
                        state <= ArbBusy;
                    end
                end
                ArbBusy: begin
                    if (hs) begin
                        if (enc_last) begin
                            byte_cnt <= '0;
                            last_gnt <= gnt;
                            state    <= ArbIdle;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end

    rs_tag_fifo #(
        .WIDTH (SRC_ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (winner),
        .pop       (tag_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule

// File: tb/tb_rs_block_arbiter.sv
// Directed bench for rs_block_arbiter with two sources and a four-entry tag FIFO.
module tb_rs_block_arbiter;
    import rs_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [15:0] src_data;
    logic        enc_valid;
    logic        enc_ready;
    logic [7:0]  enc_data;
    logic        enc_last;
    logic        cw_valid;
    logic        cw_ready;
    logic        cw_last;
    logic [0:0]  cw_src_id;
    logic        cw_tag_valid;
    logic        tag_underflow;

    int          n_cmp = 0;
    int          n_err = 0;
    int          src_cnt [2];
    logic        s_hs;
    logic        s_last;
    logic [7:0]  s_data;
    logic [1:0]  s_acc;

    rs_block_arbiter #(
        .N_SRC     (2),
        .TAG_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_data      (src_data),
        .enc_valid     (enc_valid),
        .enc_ready     (enc_ready),
        .enc_data      (enc_data),
        .enc_last      (enc_last),
        .cw_valid      (cw_valid),
        .cw_ready      (cw_ready),
        .cw_last       (cw_last),
        .cw_src_id     (cw_src_id),
        .cw_tag_valid  (cw_tag_valid),
        .tag_underflow (tag_underflow)
    );

    always #5 clk = ~clk;

    task automatic drive_data();
        src_data[7:0]  = 8'hA0 + 8'(src_cnt[0]);
        src_data[15:8] = 8'hB0 + 8'(src_cnt[1]);
    endtask

    task automatic sample();
        @(negedge clk);
        s_hs   = enc_valid & enc_ready;
        s_last = enc_last;
        s_data = enc_data;
        s_acc  = src_valid & src_ready;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (s_acc[i]) src_cnt[i]++;
        drive_data();
    endtask

    task automatic set_cw(input logic v);
        cw_valid = v;
        cw_ready = v;
        cw_last  = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = 2'b00;
        enc_ready = 1'b1;
        set_cw(1'b0);
        src_cnt   = '{0, 0};
        s_acc     = 2'b00;
        drive_data();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Streams nblk blocks; owners[k] is the expected source of block k.
    task automatic run_blocks(input int nblk, input logic [7:0] owners, input logic [1:0] vmask,
                              input int stall_src, input bit do_pop, output int cycles);
        int   k = 0;
        int   b = 0;
        int   ob [2] = '{0, 0};
        int   stall = 0;
        int   owner;
        bit   pop_next = 0;
        bit   stalling;
        logic [7:0] exp_d;
        cycles = 0;
        while (k < nblk && cycles < nblk * (int'(RS_K) + 1) + 50) begin
            owner     = int'(owners[k]);
            src_valid = vmask;
            stalling  = (owner == stall_src) && (b == 10) && (stall < 5);
            if (stalling) begin
                src_valid = vmask & ~(2'(1) << stall_src);
                stall++;
            end
            set_cw(pop_next);
            sample();
            cycles++;
            if (pop_next) begin
                n_cmp++;
                if (cw_src_id !== owners[k-1]) begin
                    n_err++;
                    $display("FAIL cw_src_id blk%0d: got %0d want %0d", k - 1, cw_src_id,
                             owners[k-1]);
                end
            end
            pop_next = 0;
            if (stalling) begin
                n_cmp++;
                if (enc_valid !== 1'b0 || src_ready !== (2'(1) << stall_src)) begin
                    n_err++;
                    $display("FAIL stall_hold: enc_valid=%b src_ready=%b", enc_valid, src_ready);
                end
            end
            if (s_hs) begin
                exp_d = (owner == 0 ? 8'hA0 : 8'hB0) + 8'(ob[owner] * int'(RS_K) + b);
                n_cmp++;
                if (s_acc !== (2'(1) << owner) || s_data !== exp_d
                    || s_last !== (b == int'(RS_K) - 1)) begin
                    n_err++;
                    $display("FAIL byte blk%0d b%0d: acc=%b data=%h last=%b want acc=%b data=%h",
                             k, b, s_acc, s_data, s_last, 2'(1) << owner, exp_d);
                end
                b++;
                if (b == int'(RS_K)) begin
                    b = 0;
                    ob[owner]++;
                    k++;
                    pop_next = do_pop;
                end
            end
            advance();
        end
        set_cw(1'b0);
        n_cmp++;
        if (k != nblk) begin
            n_err++;
            $display("FAIL blocks_done: got %0d want %0d", k, nblk);
        end
        if (pop_next) begin
            set_cw(1'b1);
            sample();
            n_cmp++;
            if (cw_src_id !== owners[k-1]) begin
                n_err++;
                $display("FAIL cw_src_id last: got %0d want %0d", cw_src_id, owners[k-1]);
            end
            advance();
            set_cw(1'b0);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        src_valid = 2'b11;
        enc_ready = 1'b1;
        set_cw(1'b1);
        src_cnt   = '{0, 0};
        s_acc     = 2'b00;
        drive_data();
        @(posedge clk);
        #1;
        sample();
        n_cmp++;
        if (src_ready !== 2'b00 || enc_valid !== 1'b0 || enc_data !== 8'h00 || enc_last !== 1'b0
            || cw_tag_valid !== 1'b0 || cw_src_id !== 1'b0 || tag_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b v=%b d=%h l=%b tv=%b id=%b uf=%b", src_ready,
                     enc_valid, enc_data, enc_last, cw_tag_valid, cw_src_id, tag_underflow);
        end
        advance();
        rst       = 1'b0;
        src_valid = 2'b00;
        set_cw(1'b0);
        sample();
        n_cmp++;
        if (tag_underflow !== 1'b0 || cw_tag_valid !== 1'b0 || enc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: uf=%b tv=%b v=%b", tag_underflow, cw_tag_valid, enc_valid);
        end
        advance();
    endtask

    task automatic test_single_source();
        int cyc;
        do_reset();
        run_blocks(3, 8'b0000_0000, 2'b01, -1, 1'b1, cyc);
        n_cmp++;
        if (cyc != 3 * (int'(RS_K) + 1)) begin
            n_err++;
            $display("FAIL single_cycles: got %0d want %0d", cyc, 3 * (int'(RS_K) + 1));
        end
    endtask

    task automatic test_alternate();
        int cyc;
        do_reset();
        run_blocks(4, 8'b0000_1010, 2'b11, -1, 1'b1, cyc);
        n_cmp++;
        if (cyc != 4 * (int'(RS_K) + 1)) begin
            n_err++;
            $display("FAIL alt_cycles: got %0d want %0d", cyc, 4 * (int'(RS_K) + 1));
        end
    endtask

    task automatic test_stall();
        int cyc;
        do_reset();
        run_blocks(3, 8'b0000_0010, 2'b11, 1, 1'b1, cyc);
        n_cmp++;
        if (cyc != 3 * (int'(RS_K) + 1) + 5) begin
            n_err++;
            $display("FAIL stall_cycles: got %0d want %0d", cyc, 3 * (int'(RS_K) + 1) + 5);
        end
    endtask

    task automatic test_fifo_full();
        int   cyc;
        int   bad = 0;
        logic [7:0] exp_d;
        do_reset();
        run_blocks(4, 8'b0000_0000, 2'b01, -1, 1'b0, cyc);
        for (int i = 0; i < 20; i++) begin
            src_valid = 2'b01;
            sample();
            if (src_ready !== 2'b00 || enc_valid !== 1'b0 || cw_tag_valid !== 1'b1) bad++;
            advance();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL full_hold: %0d bad cycles want 0", bad);
        end
        set_cw(1'b1);
        sample();
        n_cmp++;
        if (cw_src_id !== 1'b0) begin
            n_err++;
            $display("FAIL full_head: got %0d want 0", cw_src_id);
        end
        advance();
        set_cw(1'b0);
        sample();
        n_cmp++;
        if (src_ready !== 2'b00) begin
            n_err++;
            $display("FAIL full_regrant_idle: src_ready=%b want 00", src_ready);
        end
        advance();
        sample();
        exp_d = 8'hA0 + 8'(4 * int'(RS_K));
        n_cmp++;
        if (src_ready !== 2'b01 || enc_valid !== 1'b1 || enc_data !== exp_d) begin
            n_err++;
            $display("FAIL full_regrant: rdy=%b v=%b d=%h want rdy=01 v=1 d=%h", src_ready,
                     enc_valid, enc_data, exp_d);
        end
        advance();
    endtask

    task automatic test_underflow();
        do_reset();
        sample();
        n_cmp++;
        if (tag_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL uf_initial: got %b want 0", tag_underflow);
        end
        advance();
        set_cw(1'b1);
        sample();
        advance();
        set_cw(1'b0);
        sample();
        n_cmp++;
        if (tag_underflow !== 1'b1 || cw_tag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL uf_set: uf=%b tv=%b want uf=1 tv=0", tag_underflow, cw_tag_valid);
        end
        advance();
        repeat (3) begin
            sample();
            advance();
        end
        sample();
        n_cmp++;
        if (tag_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL uf_sticky: got %b want 1", tag_underflow);
        end
        advance();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        sample();
        n_cmp++;
        if (tag_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL uf_clear: got %b want 0", tag_underflow);
        end
        advance();
    endtask

    task automatic test_reset_mid_block();
        int nhs = 0;
        int cyc;
        do_reset();
        src_valid = 2'b10;
        for (int i = 0; i < 300 && nhs < 51; i++) begin
            sample();
            if (s_hs) nhs++;
            advance();
        end
        n_cmp++;
        if (nhs != 51) begin
            n_err++;
            $display("FAIL mid_progress: got %0d bytes want 51", nhs);
        end
        rst       = 1'b1;
        src_valid = 2'b11;
        sample();
        n_cmp++;
        if (src_ready !== 2'b00 || enc_valid !== 1'b0 || enc_last !== 1'b0
            || enc_data !== 8'h00 || cw_tag_valid !== 1'b0 || cw_src_id !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: rdy=%b v=%b l=%b d=%h tv=%b id=%b", src_ready,
                     enc_valid, enc_last, enc_data, cw_tag_valid, cw_src_id);
        end
        advance();
        rst = 1'b0;
        run_blocks(1, 8'b0000_0000, 2'b11, -1, 1'b1, cyc);
        n_cmp++;
        if (cyc != int'(RS_K) + 1) begin
            n_err++;
            $display("FAIL mid_restart_cycles: got %0d want %0d", cyc, int'(RS_K) + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_alternate();
        test_stall();
        test_fifo_full();
        test_underflow();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rs_block_arbiter.md
Name: rs_block_arbiter

Overview:
- Shares one rs_encoder instance between N_SRC byte-stream sources.
- Grants the encoder's s_axis input to one source for exactly one RS_K-byte message block, then re-arbitrates round-robin.
- Generates s_axis_last itself, ignoring any framing from the sources.
- Keeps a tag FIFO of grant order and presents the source id of the codeword currently leaving the encoder's m_axis.

Parameters:
N_SRC, 2, number of requesting sources (2..8)
TAG_DEPTH, 4, tag FIFO entries, power of two; bounds blocks in flight inside the encoder

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
src_valid  in  N_SRC  per-source byte valid
src_ready  out  N_SRC  per-source byte ready
src_data  in  N_SRC*8  per-source byte; source i at bits [8i+7:8i]
enc_valid  out  1  to rs_encoder s_axis_valid
enc_ready  in  1  from rs_encoder s_axis_ready
enc_data  out  8  to rs_encoder s_axis_data
enc_last  out  1  to rs_encoder s_axis_last
cw_valid  in  1  snoop of rs_encoder m_axis_valid
cw_ready  in  1  snoop of downstream m_axis_ready
cw_last  in  1  snoop of rs_encoder m_axis_last
cw_src_id  out  SRC_ID_W  source id of the codeword currently on m_axis
cw_tag_valid  out  1  tag FIFO non-empty
tag_underflow  out  1  sticky error flag: codeword end seen with tag FIFO empty

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, byte_cnt=0, gnt=0, last_gnt=N_SRC-1, tag FIFO empty, tag_underflow=0.
  - While in reset all outputs are 0, including src_ready, enc_valid and cw_tag_valid.
  - Reset mid-block abandons the partial block; the encoder must be reset alongside.
- State IDLE:
  - enc_valid=0, src_ready=0.
  - If any src_valid is set and the tag FIFO is not full: select the first requester scanning last_gnt+1, last_gnt+2, ... mod N_SRC.
  - On selection: gnt<=winner, push winner id into the tag FIFO, go to BUSY.
  - Arbitration costs exactly one cycle; no byte transfers in IDLE.
- State BUSY:
  - Combinational pass-through, no buffering: enc_valid=src_valid[gnt], enc_data=src_data[gnt], src_ready[gnt]=enc_ready; all other src_ready=0.
  - enc_last=(byte_cnt==RS_K-1).
  - byte_cnt increments on each enc_valid&enc_ready.
  - On the handshake with enc_last=1: byte_cnt<=0, last_gnt<=gnt, go to IDLE.
  - The granted source keeps the grant even if it drops valid mid-block; no timeout, no preemption.
- Throughput: one idle cycle between blocks. Sustained rate is RS_K/(RS_K+1) bytes per cycle on input.
- Tag FIFO:
  - Push at grant.
  - Pop on cw_valid&cw_ready&cw_last.
  - cw_src_id=head entry; it is 0 when empty.
  - Simultaneous push and pop: occupancy unchanged, and both operations take effect.
  - Full: IDLE holds and no grant is issued, even with requests pending.
  - Pop when empty: ignored, tag_underflow<=1 (sticky until rst).
- Fairness:
  - A source requesting continuously waits at most N_SRC-1 blocks.
  - A single active source receives back-to-back grants.
- Width rules:
  - byte_cnt is $clog2(RS_K) bits and never exceeds RS_K-1.
  - FIFO pointers are $clog2(TAG_DEPTH)+1 bits, with the MSB used to distinguish full from empty.

Decomposition:
- rs_encoder_pkg gains:
  - RS_N = RS_K + RS_PARITY_BYTES;
  - function rs_src_id_w(n), returning SRC_ID_W = max(1, $clog2(n)).
- rs_byte_t is reused for enc_data.
- One sub-module, rs_tag_fifo: synchronous FIFO of SRC_ID_W-bit entries with push, pop, full, empty and head; show-ahead read.
- The arbiter FSM, round-robin selector and byte counter stay in rs_block_arbiter.

Test Plan:
- Single source: src0 streams 3 blocks, src1 idle, cw_ready=1 -> 3*RS_K bytes pass in order; enc_last on bytes RS_K-1, 2RS_K-1, 3RS_K-1; cw_src_id=0 for all 3 codewords.
- Two sources, both always valid: src0 fills 0xA0+n, src1 fills 0xB0+n -> blocks alternate 0,1,0,1; no byte interleaving inside a block; cw_src_id sequence 0,1,0,1.
- Mid-block stalls: src1 drops valid for 5 cycles at byte 10 while src0 requests -> grant stays on src1 until its byte RS_K-1; src0 is granted the next block.
- Tag FIFO full: cw_ready=0 for a long period, TAG_DEPTH=4 -> exactly 4 grants, then IDLE holds with src_ready=0; first codeword-end pop releases the 5th grant within 2 cycles.
- Underflow: pulse cw_valid&cw_ready&cw_last with the FIFO empty -> tag_underflow=1 and stays set; rst=1 for one cycle clears it.
- Reset mid-block: assert rst after byte 50 of a block -> next cycle all outputs 0 and byte_cnt=0; the next grant goes to src0 and enc_last lands on its byte RS_K-1.
